// File: rtl/data_memory_pkg.sv
// Shared memory-system types for the line-granular data memory.
// Line and address widths, offset width and FSM state encoding.
package data_memory_pkg;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int OFF_W  = 5;
   localparam int CNT_W  = 8;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_e;

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the cache miss controller and memory.
// The pl_* signals are a preload port used to seed line contents.
interface data_memory_if;
   import data_memory_pkg::*;

   logic  enable_i;
   logic  write_i;
   addr_t addr_i;
   line_t data_i;
   logic  ack_o;
   line_t data_o;
   logic  busy_o;

   logic  pl_en_i;
   addr_t pl_addr_i;
   line_t pl_data_i;

   modport master (
      output enable_i, write_i, addr_i, data_i,
      output pl_en_i, pl_addr_i, pl_data_i,
      input  ack_o, data_o, busy_o
   );

   modport slave (
      input  enable_i, write_i, addr_i, data_i,
      input  pl_en_i, pl_addr_i, pl_data_i,
      output ack_o, data_o, busy_o
   );

endinterface

// File: rtl/data_memory_array.sv
// DEPTH x LINE_W line storage: synchronous write, combinational read.
// The preload port takes priority over the functional write port.
module data_memory_array
   import data_memory_pkg::*;
#(
   parameter int DEPTH = 512,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] idx_i,
   input  line_t            wdata_i,
   output line_t            rdata_o,
   input  logic             pl_en_i,
   input  logic [IDX_W-1:0] pl_idx_i,
   input  line_t            pl_data_i
);

   line_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (pl_en_i) begin
         mem_q[pl_idx_i] <= pl_data_i;
      end else if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_memory.sv
// Fixed-latency line memory: IDLE -> BUSY -> ACK, one-cycle ack pulse,
// registered read data held until the next read completes.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int LATENCY = 10,
   parameter int DEPTH   = 512
) (
   input  logic        clk_i,
   input  logic        rst_i,
   data_memory_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   line_t            wdata_q, wdata_d;
   logic             ack_q, ack_d;
   line_t            rdata_q, rdata_d;

   logic             accept;
   logic             mem_we;
   line_t            mem_rdata;
   logic             unused_addr;

   assign unused_addr = ^{bus.addr_i, bus.pl_addr_i};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      ack_d   = 1'b0;
      rdata_d = rdata_q;
      accept  = 1'b0;
      mem_we  = 1'b0;

      unique case (state_q)
         IDLE: begin
            accept = bus.enable_i;
         end
         BUSY: begin
            if (cnt_q == LAT_C) begin
               state_d = ACK;
               ack_d   = 1'b1;
               if (wr_q) begin
                  mem_we = ~rst_i;
               end else begin
                  rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end
         ACK: begin
            // The edge leaving ACK is the first IDLE sampling edge.
            state_d = IDLE;
            accept  = bus.enable_i;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d = BUSY;
         cnt_d   = ONE_C;
         wr_d    = bus.write_i;
         idx_d   = bus.addr_i[OFF_W +: IDX_W];
         wdata_d = bus.data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   data_memory_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i     (clk_i),
      .we_i      (mem_we),
      .idx_i     (idx_q),
      .wdata_i   (wdata_q),
      .rdata_o   (mem_rdata),
      .pl_en_i   (bus.pl_en_i),
      .pl_idx_i  (bus.pl_addr_i[OFF_W +: IDX_W]),
      .pl_data_i (bus.pl_data_i)
   );

   assign bus.ack_o  = ack_q;
   assign bus.data_o = rdata_q;
   assign bus.busy_o = (state_q != IDLE);

endmodule

// File: doc/data_memory.md
# data_memory

Line-granular main-memory model directly downstream of the data cache. It accepts one 256-bit line read or write per request and completes it after a fixed, parameterised latency. It signals completion with a single-cycle acknowledge and holds read data stable afterward. The cache's miss controller performs write-backs and refills through this block.

## Interface
- `LATENCY`, default 10: cycles from request acceptance to ack; legal range 1..255.
- `DEPTH`, default 512: number of 256-bit lines stored; must be a power of two.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: reset; synchronous, active-high.
- `enable_i`  in  1: request valid; sampled only in IDLE.
- `write_i`  in  1: 1 = line write, 0 = line read; sampled with the request.
- `addr_i`  in  32: byte address.
  - Line index = `addr_i[log2(DEPTH)+4:5]`.
  - Bits [4:0] are ignored.
  - Upper bits are ignored, so addresses alias modulo DEPTH lines.
- `data_i`  in  256: write line; sampled with the request.
- `ack_o`  out  1: one-cycle completion pulse.
- `data_o`  out  256: read line; registered.
- `busy_o`  out  1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE, then BUSY, then ACK, then back to IDLE.
- IDLE:
  - If `enable_i` is high at the edge, latch `write_i`, the line index and `data_i`.
  - Load the counter with 1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Increment the counter each edge.
  - Inputs are ignored, including `enable_i` dropping or `addr_i`/`data_i` changing. The latched request completes.
  - When the counter equals LATENCY, perform the access:
    - Write: commit the latched line to the array.
    - Read: load `data_o` from the array at the latched index.
  - In the same edge, set `ack_o` and go to ACK.
- ACK:
  - `ack_o` is high for exactly this cycle.
  - Next edge: clear `ack_o`, go to IDLE.
  - A request present during ACK is not accepted. It is sampled on the first IDLE edge.
- `data_o`:
  - Changes only on read completion.
  - Holds its value through writes and idle periods, because the cache captures it in the cycle after ack.
- Reset:
  - State IDLE, counter 0, `ack_o` 0, `data_o` 0, `busy_o` 0.
  - The array is not cleared; the bench preloads it.
- Reset during BUSY: the transaction is abandoned and a pending write is not committed.
- Reset in the same edge as completion: reset wins; no ack, no commit.

## Timing
- Request sampled at edge E0 in IDLE. `ack_o` rises at edge E0+LATENCY and falls at edge E0+LATENCY+1.
- `data_o` carries read data from edge E0+LATENCY.
- With LATENCY=1, BUSY lasts one cycle.
- Back-to-back requests (write-back followed by refill):
  - The second request, held through the ack cycle, is sampled at edge E0+LATENCY+1.
  - The minimum request spacing is therefore LATENCY+1 cycles.
- Read-after-write to the same line returns the newly written data. The write is committed before the read is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared memory-system package holds:
  - `LINE_W=256` and `ADDR_W=32`;
  - the offset width 5;
  - the state enum {IDLE, BUSY, ACK}, 2 bits.
- Sub-module `data_memory_array`: DEPTH×LINE_W storage with synchronous write and combinational read, plus a bench preload hook.
- The top level holds the FSM, the counter (8 bits), the request latches, and the `data_o`/`ack_o` registers.

## Test plan
- Read hit on preloaded data:
  - Stimulus: preload line 3 = 256'hA5 repeated, LATENCY=10; `enable_i`=1, `write_i`=0, `addr_i`=32'h0000_0060 at E0.
  - Response: `ack_o` high only at E0+10; `data_o`=256'hA5 repeated; `busy_o` high from E0 to E0+10.
- Write then read:
  - Stimulus: write 256'h1234 to addr 32'h0000_0400; after ack, read the same address.
  - Response: the read returns 256'h1234.
  - Also check: a read of addr 32'h0000_4400 with DEPTH=512 aliases to the same line and returns 256'h1234.
- Write-back then refill:
  - Stimulus: hold `enable_i` high; write line 5, and on the cycle after ack switch `write_i` to 0 with a new address.
  - Response: the second ack arrives exactly LATENCY+1 cycles after the first.
  - Also check: `data_o` is unchanged by the write.
- Mid-request disturbance:
  - Stimulus: drop `enable_i` and change `addr_i`/`data_i` at E0+3 of a write.
  - Response: the write still commits the latched data to the latched line, and the ack arrives at E0+10.
- Reset mid-operation:
  - Stimulus: assert `rst_i` at E0+5 of a write of 256'hFF to line 7 (preloaded 0).
  - Response: no ack; `busy_o`=0 and `data_o`=0 after reset; a subsequent read of line 7 returns 0.
- Minimum latency:
  - Stimulus: LATENCY=1; issue a read.
  - Response: ack at E0+1; the next request is accepted at E0+2.
